rf_access_arbiter: RTL

- Sequences and shares the 4-entry register file between two requesters: the CPU core and the debug port.
- Each requester has a valid/ready request channel and a pulsed response channel.
- Applies fixed CPU priority, with an anti-starvation counter that guarantees debug access.
- Provides a halt state machine so the debugger can freeze CPU register traffic and own the register file exclusively.

---
 rtl/rf_access_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter
//   Shares a small register file between the CPU core and the debug port.
//   Each requester uses a valid/ready request channel (req/ready) and gets a
//   one-cycle response pulse (rsp_valid/rdata) two cycles after acceptance.
//   The CPU has fixed priority, and a starvation counter forces a debug grant
//   after DBG_STARVE_LIMIT consecutive CPU wins. A RUN/DRAIN/HALTED state
//   machine lets the debugger freeze CPU traffic and own the register file.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   cpu_req/we/addr/wdata, cpu_ready    CPU request channel
//   cpu_rsp_valid, cpu_rdata            CPU response pulse / read data
//   dbg_req/we/addr/wdata, dbg_ready    debug request channel
//   dbg_rsp_valid, dbg_rdata            debug response pulse / read data
//   dbg_halt, halted                    halt request level / halted status
//   rf_ld_ce, rf_st_ce, rf_addr,        register file strobes, address,
//   rf_wdata, rf_rdata                  write data and combinational read data
module rf_access_arbiter #(
  parameter int REG_ADDR_WIDTH   = 2,
  parameter int DATA_WIDTH       = 8,
  parameter int DBG_STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [REG_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]     cpu_wdata,
  output logic                      cpu_ready,
  output logic                      cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0]     cpu_rdata,
  input  logic                      dbg_req,
  input  logic                      dbg_we,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0]     dbg_wdata,
  output logic                      dbg_ready,
  output logic                      dbg_rsp_valid,
  output logic [DATA_WIDTH-1:0]     dbg_rdata,
  input  logic                      dbg_halt,
  output logic                      halted,
  output logic                      rf_ld_ce,
  output logic                      rf_st_ce,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  input  logic [DATA_WIDTH-1:0]     rf_rdata
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIMIT = 4'(DBG_STARVE_LIMIT);

  // Saturating increment for the starvation counter: never wraps past lim.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
    return (cnt >= lim) ? lim : cnt + 4'd1;
  endfunction

  state_t                    state;
  logic [3:0]                starve_cnt;
  logic                      starve_hit;
  logic                      cpu_grant;
  logic                      dbg_grant;

  logic                      vld_p1;
  logic                      own_dbg_p1;
  logic                      we_p1;
  logic [REG_ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0]     wdata_p1;

  // ---- p0: arbitration (combinational ready) ----
  // Ready is forced low while reset is asserted so nothing is ever accepted
  // into the pipeline during a reset cycle.
  always_comb begin
    starve_hit = dbg_req && (starve_cnt >= STARVE_LIMIT);
    cpu_grant  = 1'b0;
    dbg_grant  = 1'b0;
    if (rst_n) begin
      case (state)
        ST_RUN: begin
          cpu_grant = cpu_req && !starve_hit;
          dbg_grant = dbg_req && !cpu_grant;
        end
        default: dbg_grant = dbg_req;
      endcase
    end
  end

  assign cpu_ready = cpu_grant;
  assign dbg_ready = dbg_grant;

  // Starvation counter and halt state machine.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      starve_cnt <= 4'd0;
      halted     <= 1'b0;
    end else begin
      if (!dbg_req || dbg_grant)
        starve_cnt <= 4'd0;
      else if (cpu_grant)
        starve_cnt <= sat_inc(starve_cnt, STARVE_LIMIT);

      case (state)
        ST_RUN: begin
          if (dbg_halt)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Once the stage is empty the only outstanding work is the response
          // already on the outputs; a debug op granted here is fine since
          // debug keeps access while halted.
          if (!dbg_halt) begin
            state <= ST_RUN;
          end else if (!vld_p1) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!dbg_halt) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // ---- p1: stage register drives the register file ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      own_dbg_p1 <= 1'b0;
      we_p1      <= 1'b0;
      addr_p1    <= '0;
      wdata_p1   <= '0;
    end else begin
      vld_p1 <= cpu_grant || dbg_grant;
      if (cpu_grant || dbg_grant) begin
        own_dbg_p1 <= dbg_grant;
        we_p1      <= dbg_grant ? dbg_we    : cpu_we;
        addr_p1    <= dbg_grant ? dbg_addr  : cpu_addr;
        wdata_p1   <= dbg_grant ? dbg_wdata : cpu_wdata;
      end
    end
  end

  // Strobes are gated by rst_n so an op caught in the stage during reset
  // never commits to the register file.
  assign rf_st_ce = rst_n && vld_p1 && we_p1;
  assign rf_ld_ce = rst_n && vld_p1 && !we_p1;
  assign rf_addr  = addr_p1;
  assign rf_wdata = wdata_p1;

  // ---- p2: response registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rsp_valid <= 1'b0;
      dbg_rsp_valid <= 1'b0;
      cpu_rdata     <= '0;
      dbg_rdata     <= '0;
    end else begin
      cpu_rsp_valid <= vld_p1 && !own_dbg_p1;
      dbg_rsp_valid <= vld_p1 && own_dbg_p1;
      if (vld_p1 && !own_dbg_p1 && !we_p1)
        cpu_rdata <= rf_rdata;
      if (vld_p1 && own_dbg_p1 && !we_p1)
        dbg_rdata <= rf_rdata;
    end
  end

endmodule
